// File: rtl/spi_debug_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_debug_master
//  Description : Host-side master for the pipeline's parallel (word-wide)
//                debug SPI. Runs bursts of word exchanges against one
//                pipeline-stage slave selected by a one-hot chip select.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_debug_master #(
    parameter int NB_BITS   = 32,
    parameter int NB_CS     = 4,
    parameter int NB_SEL    = 2,
    parameter int NB_CNT    = 8,
    parameter int SCLK_HALF = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,      // asynchronous, active low
    input  logic               i_start,
    input  logic [NB_SEL-1:0]  i_sel,
    input  logic [NB_CNT-1:0]  i_nwords,
    input  logic [NB_BITS-1:0] i_wdata,
    input  logic               i_wvalid,
    output logic               o_wready,
    output logic [NB_BITS-1:0] o_rdata,
    output logic               o_rvalid,
    output logic               o_busy,
    output logic               o_done,
    output logic [NB_BITS-1:0] o_MOSI,
    output logic               o_SCLK,
    output logic [NB_CS-1:0]   o_SPI_cs,
    input  logic [NB_BITS-1:0] i_MISO
);

    // Phase counter only needs to count up to SCLK_HALF-1.
    localparam int NB_PH = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [NB_PH-1:0] c_PH_LAST = NB_PH'(SCLK_HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SETUP = 3'd2,
        S_HIGH  = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             r_state;
    logic [NB_PH-1:0]   r_ph;
    logic [NB_CNT-1:0]  r_cnt;
    logic               r_sel_ok;
    logic [NB_CS-1:0]   r_cs;
    logic               r_sclk;
    logic [NB_BITS-1:0] r_mosi;
    logic [NB_BITS-1:0] r_rdata;
    logic               r_rvalid;
    logic               r_wready;
    logic               r_busy;
    logic               r_done;

    logic [NB_CS-1:0]   w_cs_dec;
    logic               w_sel_ok;

    // Decode the requested stage into a one-hot select; out-of-range selects nobody.
    always_comb begin
        w_cs_dec = '0;
        w_sel_ok = 1'b0;
        for (int i = 0; i < NB_CS; i++) begin
            if (int'(i_sel) == i) begin
                w_cs_dec[i] = 1'b1;
                w_sel_ok    = 1'b1;
            end
        end
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state  <= S_IDLE;
            r_ph     <= '0;
            r_cnt    <= '0;
            r_sel_ok <= 1'b0;
            r_cs     <= '0;
            r_sclk   <= 1'b0;
            r_mosi   <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_wready <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cs     <= w_cs_dec;
                        r_sel_ok <= w_sel_ok;
                        r_cnt    <= i_nwords;   // 0 wraps to a full 2^NB_CNT burst
                        r_busy   <= 1'b1;
                        r_wready <= 1'b1;
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (i_wvalid && r_wready) begin
                        r_mosi   <= i_wdata;
                        r_wready <= 1'b0;
                        r_ph     <= '0;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_ph == c_PH_LAST) begin
                        r_ph    <= '0;
                        // With no slave selected SCLK stays low so it is never high while cs is low.
                        r_sclk  <= r_sel_ok;
                        r_state <= S_HIGH;
                    end else begin
                        r_ph <= r_ph + NB_PH'(1);
                    end
                end
                S_HIGH: begin
                    if (r_ph == c_PH_LAST) begin
                        r_ph     <= '0;
                        r_sclk   <= 1'b0;
                        r_rdata  <= i_MISO;
                        r_rvalid <= 1'b1;
                        r_cnt    <= r_cnt - NB_CNT'(1);
                        if (r_cnt != NB_CNT'(1)) begin
                            r_wready <= 1'b1;
                            r_state  <= S_LOAD;
                        end else begin
                            r_state <= S_HOLD;
                        end
                    end else begin
                        r_ph <= r_ph + NB_PH'(1);
                    end
                end
                S_HOLD: begin
                    if (r_ph == c_PH_LAST) begin
                        r_ph    <= '0;
                        r_cs    <= '0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_ph <= r_ph + NB_PH'(1);
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_wready = r_wready;
    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_MOSI   = r_mosi;
    assign o_SCLK   = r_sclk;
    assign o_SPI_cs = r_cs;

endmodule
`default_nettype wire
